bluetooth_frame_tx: RTL and testbench

Upstream packetiser for the Bluetooth UART byte transmitter. It accepts one frame of fetal-ECG result words from the processing pipeline and serialises it into bytes. Each byte is handed to the transmitter with a start/done handshake. The byte sequence is header, length, payload bytes, then an 8-bit additive checksum. A watchdog aborts the frame if the transmitter stops responding.

---
 rtl/bluetooth_frame_tx.sv | 175 +++++++++++++++++
 tb/tb_bluetooth_frame_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_frame_tx.sv
// Frame packetiser for the Bluetooth UART byte transmitter: header, length,
// payload bytes (word 0 first, MSB first) and an additive checksum, with a watchdog.
module bluetooth_frame_tx #(
    parameter int         N_BITS       = 8,
    parameter int         N_WORDS      = 4,
    parameter int         WORD_BITS    = 16,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_frame_valid,
    input  logic [N_WORDS*WORD_BITS-1:0] in_frame_data,
    output logic                         out_frame_ready,
    output logic                         out_tx_start,
    output logic [N_BITS-1:0]            out_tx_cmd,
    input  logic                         in_tx_active,
    input  logic                         in_tx_done,
    output logic                         out_busy,
    output logic                         out_frame_done,
    output logic                         out_error
);

    localparam int FRAME_BITS     = N_WORDS * WORD_BITS;
    localparam int N_PAYLOAD      = FRAME_BITS / 8;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;
    localparam int N_BYTES        = N_PAYLOAD + 3;
    localparam int IDX_W          = $clog2(N_BYTES);
    localparam int WD_W           = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [7:0]       LEN_BYTE = 8'(N_PAYLOAD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    tx_start_q, tx_start_d;
    logic [N_BITS-1:0]       tx_cmd_q, tx_cmd_d;
    logic                    frame_done_q, frame_done_d;
    logic                    error_q, error_d;

    logic [7:0]              payload_bytes [N_PAYLOAD];
    logic [7:0]              cur_byte;
    logic                    cur_in_csum;
    logic                    ready;

    // Payload byte p lives in word p/BYTES_PER_WORD, most-significant byte first.
    genvar gi;
    generate
        for (gi = 0; gi < N_PAYLOAD; gi++) begin : g_payload
            localparam int WORD_IDX     = gi / BYTES_PER_WORD;
            localparam int BYTE_IN_WORD = gi % BYTES_PER_WORD;
            assign payload_bytes[gi] =
                frame_q[WORD_IDX*WORD_BITS + (BYTES_PER_WORD-1-BYTE_IN_WORD)*8 +: 8];
        end
    endgenerate

    always_comb begin
        cur_byte = 8'h00;
        if (idx_q == '0) begin
            cur_byte = HEADER;
        end else if (idx_q == IDX_W'(1)) begin
            cur_byte = LEN_BYTE;
        end else if (idx_q == LAST_IDX) begin
            cur_byte = csum_q;
        end else begin
            for (int k = 0; k < N_PAYLOAD; k++) begin
                if (idx_q == IDX_W'(k + 2)) begin
                    cur_byte = payload_bytes[k];
                end
            end
        end
    end

    assign cur_in_csum = (idx_q != '0) && (idx_q != LAST_IDX);

    // The transmitter has no reset, so a byte still in flight blocks acceptance.
    assign ready = (state_q == IDLE) && !in_tx_active && !in_tx_done;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        wd_d         = wd_q;
        tx_start_d   = 1'b0;
        tx_cmd_d     = tx_cmd_q;
        frame_done_d = 1'b0;
        error_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_frame_valid && ready) begin
                    frame_d = in_frame_data;
                    csum_d  = 8'h00;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_cmd_d   = N_BITS'(cur_byte);
                tx_start_d = 1'b1;
                wd_d       = '0;
                if (cur_in_csum) begin
                    csum_d = csum_q + cur_byte;
                end
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (in_tx_done) begin
                    state_d = GAP;
                end else if (wd_q == WD_LIMIT) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                // Done is high for two cycles; advance only once it has fallen.
                if (!in_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            idx_q        <= '0;
            csum_q       <= 8'h00;
            wd_q         <= '0;
            tx_start_q   <= 1'b0;
            tx_cmd_q     <= '0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            wd_q         <= wd_d;
            tx_start_q   <= tx_start_d;
            tx_cmd_q     <= tx_cmd_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    assign out_frame_ready = ready;
    assign out_tx_start    = tx_start_q;
    assign out_tx_cmd      = tx_cmd_q;
    assign out_busy        = (state_q != IDLE);
    assign out_frame_done  = frame_done_q;
    assign out_error       = error_q;

endmodule

// File: tb/tb_bluetooth_frame_tx.sv
// Bench for bluetooth_frame_tx: table of frames with hand-computed byte streams,
// plus back-to-back, watchdog and reset-mid-frame sequences against a UART model.
module tb_bluetooth_frame_tx;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] bclks;
        logic [87:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_frame_valid;
    logic [63:0] in_frame_data;
    logic        out_frame_ready;
    logic        out_tx_start;
    logic [7:0]  out_tx_cmd;
    logic        out_busy;
    logic        out_frame_done;
    logic        out_error;

    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_hang   = 1'b0;
    logic        m_kick   = 1'b0;
    int          m_cnt    = 0;
    int          m_dcnt   = 0;
    int          bit_clks = 5;
    int          hang_at  = 0;

    int          cyc = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          start_cyc = 0, err_cyc = 0;
    int          ready_viol = 0, start_busy = 0, long_start = 0, cmd_viol = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  cmd_hold = 8'h00;
    logic [7:0]  tx_log [$];

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    bluetooth_frame_tx dut (
        .clk             (clk),
        .rst             (rst),
        .in_frame_valid  (in_frame_valid),
        .in_frame_data   (in_frame_data),
        .out_frame_ready (out_frame_ready),
        .out_tx_start    (out_tx_start),
        .out_tx_cmd      (out_tx_cmd),
        .in_tx_active    (m_active),
        .in_tx_done      (m_done),
        .out_busy        (out_busy),
        .out_frame_done  (out_frame_done),
        .out_error       (out_error)
    );

    // UART byte transmitter model: 10 bit-times active, then done for 2 cycles.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= out_tx_start;
        if (out_tx_start && prev_start) long_start <= long_start + 1;
        if (out_frame_done) done_cnt <= done_cnt + 1;
        if (out_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (out_frame_ready && (out_busy || m_active || m_done)) ready_viol <= ready_viol + 1;
        if ((m_active || m_done) && (out_tx_cmd != cmd_hold)) cmd_viol <= cmd_viol + 1;
        if (m_kick) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_hang   <= 1'b0;
        end else if (out_tx_start) begin
            if (m_active || m_done) start_busy <= start_busy + 1;
            tx_log.push_back(out_tx_cmd);
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            cmd_hold  <= out_tx_cmd;
            m_active  <= 1'b1;
            m_cnt     <= 10 * bit_clks - 1;
            m_hang    <= (start_cnt + 1 == hang_at);
        end else if (m_active) begin
            if (!m_hang) begin
                if (m_cnt == 0) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_dcnt   <= 1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (m_done) begin
            if (m_dcnt == 0) m_done <= 1'b0;
            else m_dcnt <= m_dcnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!out_frame_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(out_frame_ready), 64'd1);
    endtask

    task automatic wait_end(input int limit, output logic got_done, output logic got_err);
        int n;
        n = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (out_frame_done) got_done = 1'b1;
            if (out_error) got_err = 1'b1;
            if (got_done || got_err) break;
        end
    endtask

    task automatic check_bytes(input int base, input vec_t v, input string tag);
        logic [7:0] e;
        logic [7:0] a;
        for (int i = 0; i < 11; i++) begin
            e = v.exp[87-8*i -: 8];
            a = (tx_log.size() > base + i) ? tx_log[base+i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 64'(a), 64'(e));
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int   base, s0, d0, e0, c0;
        logic gd, ge;
        bit_clks = int'(v.bclks);
        wait_ready(tag);
        base = tx_log.size();
        s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; c0 = cmd_viol;
        in_frame_data  = v.data;
        in_frame_valid = 1'b1;
        @(negedge clk);
        in_frame_valid = 1'b0;
        in_frame_data  = ~v.data;
        check({tag, "_busy"}, 64'(out_busy), 64'd1);
        wait_end(20000, gd, ge);
        check({tag, "_done_pulse"}, 64'(gd), 64'd1);
        check({tag, "_done_after_tx_idle"}, 64'(m_done | m_active), 64'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 64'(out_frame_done), 64'd0);
        check({tag, "_idle"}, 64'(out_busy), 64'd0);
        check({tag, "_starts"}, 64'(start_cnt - s0), 64'd11);
        check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_err_count"}, 64'(err_cnt - e0), 64'd0);
        check({tag, "_cmd_stable"}, 64'(cmd_viol - c0), 64'd0);
        check_bytes(base, v, tag);
        $display("frame %s: data=%h starts=%0d checksum=%02h", tag, v.data,
                 start_cnt - s0, v.exp[7:0]);
    endtask

    initial begin
        vec_t vecs [5];
        int   base, s0, d0, e0, n;
        logic gd, ge;

        rst = 1'b1;
        in_frame_valid = 1'b0;
        in_frame_data  = 64'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx_start", 64'(out_tx_start), 64'd0);
        check("reset_tx_cmd", 64'(out_tx_cmd), 64'd0);
        check("reset_busy", 64'(out_busy), 64'd0);
        check("reset_frame_done", 64'(out_frame_done), 64'd0);
        check("reset_error", 64'(out_error), 64'd0);
        check("reset_ready", 64'(out_frame_ready), 64'd1);

        vecs[0].data = 64'hFF00_0001_ABCD_1234; vecs[0].bclks = 16'd55;
        vecs[0].exp  = 88'hA5_08_12_34_AB_CD_00_01_FF_00_C6;
        vecs[1].data = 64'hFFFF_FFFF_FFFF_FFFF; vecs[1].bclks = 16'd5;
        vecs[1].exp  = 88'hA5_08_FF_FF_FF_FF_FF_FF_FF_FF_00;
        vecs[2].data = 64'h0000_0000_0000_0000; vecs[2].bclks = 16'd5;
        vecs[2].exp  = 88'hA5_08_00_00_00_00_00_00_00_00_08;
        vecs[3].data = 64'h0807_0605_0403_0201; vecs[3].bclks = 16'd5;
        vecs[3].exp  = 88'hA5_08_02_01_04_03_06_05_08_07_2C;
        vecs[4].data = 64'h8000_0000_0000_0080; vecs[4].bclks = 16'd5;
        vecs[4].exp  = 88'hA5_08_00_80_00_00_00_00_80_00_08;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: valid stays high; data switches to frame B right after A is taken.
        bit_clks = 5;
        wait_ready("b2b");
        base = tx_log.size(); s0 = start_cnt; d0 = done_cnt;
        in_frame_data  = vecs[3].data;
        in_frame_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_busy && n < 50);
        check("b2b_first_accept", 64'(out_busy), 64'd1);
        in_frame_data = vecs[4].data;
        wait_end(20000, gd, ge);
        check("b2b_first_done", 64'(gd), 64'd1);
        @(negedge clk);
        check("b2b_second_accept", 64'(out_busy), 64'd1);
        check("b2b_first_complete", 64'(done_cnt - d0), 64'd1);
        check("b2b_first_starts", 64'(start_cnt - s0), 64'd11);
        in_frame_valid = 1'b0;
        wait_end(20000, gd, ge);
        check("b2b_second_done", 64'(gd), 64'd1);
        @(negedge clk);
        check("b2b_total_starts", 64'(start_cnt - s0), 64'd22);
        check_bytes(base, vecs[3], "b2b_a");
        check_bytes(base + 11, vecs[4], "b2b_b");
        $display("frame b2b: two frames, starts=%0d", start_cnt - s0);

        // Watchdog: the transmitter hangs on the byte with index 3.
        bit_clks = 5;
        wait_ready("wd");
        base = tx_log.size(); s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
        hang_at = start_cnt + 4;
        in_frame_data  = vecs[0].data;
        in_frame_valid = 1'b1;
        @(negedge clk);
        in_frame_valid = 1'b0;
        wait_end(3000, gd, ge);
        check("wd_error_pulse", 64'(ge), 64'd1);
        check("wd_no_done", 64'(gd), 64'd0);
        @(negedge clk);
        check("wd_latency", 64'(err_cyc - start_cyc), 64'd1024);
        check("wd_idle", 64'(out_busy), 64'd0);
        check("wd_ready_blocked", 64'(out_frame_ready), 64'd0);
        check("wd_hung_byte", 64'((tx_log.size() > base + 3) ? tx_log[base+3] : 8'hxx), 64'h34);
        repeat (20) @(negedge clk);
        check("wd_starts", 64'(start_cnt - s0), 64'd4);
        check("wd_err_count", 64'(err_cnt - e0), 64'd1);
        check("wd_done_count", 64'(done_cnt - d0), 64'd0);
        $display("frame wd: error after %0d cycles", err_cyc - start_cyc);
        m_kick = 1'b1;
        @(negedge clk);
        m_kick  = 1'b0;
        hang_at = 0;

        // Reset while byte 5 is still on the wire.
        bit_clks = 5;
        wait_ready("rst_pre");
        base = tx_log.size(); d0 = done_cnt; e0 = err_cnt;
        in_frame_data  = vecs[3].data;
        in_frame_valid = 1'b1;
        @(negedge clk);
        in_frame_valid = 1'b0;
        n = 0;
        while (tx_log.size() < base + 6 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_byte5", 64'(tx_log.size() - base), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx_start", 64'(out_tx_start), 64'd0);
        check("rst_tx_cmd", 64'(out_tx_cmd), 64'd0);
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_frame_done", 64'(out_frame_done), 64'd0);
        check("rst_error", 64'(out_error), 64'd0);
        check("rst_ready_blocked", 64'(out_frame_ready), 64'd0);
        wait_ready("rst_recover");
        check("rst_tx_idle_at_ready", 64'(m_active | m_done), 64'd0);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_no_error", 64'(err_cnt - e0), 64'd0);
        $display("frame rst: dropped after %0d bytes", tx_log.size() - base);
        run_frame(vecs[4], "after_rst");

        check("ready_while_busy", 64'(ready_viol), 64'd0);
        check("start_while_tx_busy", 64'(start_busy), 64'd0);
        check("start_pulse_width", 64'(long_start), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
